// File: rtl/counter_table_updater_if.sv
// Bus bundle between the counter-table updater, the commit/fetch clients and
// the single-port saturating-counter table.
interface counter_table_updater_if #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 3
);
    // Commit-side update requests
    logic             UpdValid;
    logic             UpdRdy;
    logic [IDX_W-1:0] UpdIdx;
    logic             UpdTaken;
    // Fetch-side lookup
    logic             LkValid;
    logic [IDX_W-1:0] LkAddr;
    logic [CNT_W-1:0] LkDout;
    logic             LkDoutValid;
    // Table port
    logic [IDX_W-1:0] TblAddr;
    logic             TblWen;
    logic [CNT_W-1:0] TblDin;
    logic [CNT_W-1:0] TblDout;
    // Status
    logic             Busy;

    // Environment side: clients and table
    modport master (
        output UpdValid, UpdIdx, UpdTaken, LkValid, LkAddr, TblDout,
        input  UpdRdy, LkDout, LkDoutValid, TblAddr, TblWen, TblDin, Busy
    );

    // Updater side
    modport slave (
        input  UpdValid, UpdIdx, UpdTaken, LkValid, LkAddr, TblDout,
        output UpdRdy, LkDout, LkDoutValid, TblAddr, TblWen, TblDin, Busy
    );
endinterface

// File: rtl/counter_table_updater.sv
// Write-side controller for the saturating-counter table: buffers branch
// resolutions in a small FIFO and applies them by read-modify-write through
// the shared table port, always yielding the port to fetch lookups.
module counter_table_updater #(
    parameter int IDX_W      = 8,
    parameter int CNT_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  Clk,
    input logic                  Rest,
    counter_table_updater_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RD, CAP, WB} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] fifo_idx   [FIFO_DEPTH];
    logic             fifo_taken [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, empty, push, pop;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic [CNT_W-1:0] cnt_reg, new_cnt;
    logic             lk_dout_valid;
    logic [IDX_W-1:0] tbl_addr;
    logic             tbl_wen;
    logic [CNT_W-1:0] tbl_din;

    assign full       = (count == DEPTH_CNT);
    assign empty      = (count == '0);
    assign push       = bus.UpdValid & ~full;
    assign pop        = (state == WB) & ~bus.LkValid;
    assign head_idx   = empty ? '0 : fifo_idx[rd_ptr];
    assign head_taken = fifo_taken[rd_ptr];

    assign bus.UpdRdy      = ~full;
    assign bus.LkDout      = bus.TblDout;
    assign bus.LkDoutValid = lk_dout_valid;
    assign bus.Busy        = ~empty | (state != IDLE);
    assign bus.TblAddr     = tbl_addr;
    assign bus.TblWen      = tbl_wen;
    assign bus.TblDin      = tbl_din;

    // Saturating step of the captured counter in the head entry's direction
    always_comb begin
        new_cnt = cnt_reg;
        if (head_taken) begin
            if (cnt_reg != CNT_MAX) new_cnt = cnt_reg + 1'b1;
        end else begin
            if (cnt_reg != '0) new_cnt = cnt_reg - 1'b1;
        end
    end

    // FIFO payload storage; contents are don't-care while the slot is free
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_idx[wr_ptr]   <= bus.UpdIdx;
            fifo_taken[wr_ptr] <= bus.UpdTaken;
        end
    end

    // FIFO pointers and occupancy; reset flushes any queued updates
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // RMW sequencer state register
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: RD/WB repeat while a lookup holds the port; a push into an
    // empty FIFO is noticed the same cycle so RD follows acceptance directly
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty || push) state_nxt = RD;
            RD:      if (!bus.LkValid) state_nxt = CAP;
            CAP:     state_nxt = WB;
            WB:      if (!bus.LkValid) state_nxt = ((count > ONE_CNT) || push) ? RD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the table read data the cycle after the RD request
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest)              cnt_reg <= '0;
        else if (state == CAP) cnt_reg <= bus.TblDout;
    end

    // Lookup result valid flag tracks the request one cycle later
    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) lk_dout_valid <= 1'b0;
        else      lk_dout_valid <= bus.LkValid;
    end

    // Table port mux: lookup first, otherwise the head entry's address
    always_comb begin
        tbl_addr = head_idx;
        tbl_wen  = 1'b0;
        tbl_din  = (state == WB) ? new_cnt : '0;
        if (bus.LkValid)       tbl_addr = bus.LkAddr;
        else if (state == WB)  tbl_wen  = 1'b1;
    end
endmodule
